hex_rate_monitor: RTL and testbench
===================================

Name: hex_rate_monitor

Overview:
- Receive-side monitor for a 7-segment digit bus driven by the slow counter's hex display path. Decodes the active-low segment pattern back to a 4-bit digit and checks that the digit advances by exactly +1 mod 16.
- Measures the clock-cycle interval between advances, which yields the observed counting rate.
- Used as an on-board checker and bench monitor for the counter/rate-divider chain.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (min 1).
- CNT_W, 28, width of the interval counter and the period output.

Ports:
- clock  input  1  system clock (50 MHz on board).
- reset_n  input  1  reset; asynchronous, active-low.
- enable  input  1  1 = monitor runs; 0 = all state frozen, no pulses.
- seg_in  input  7  active-low segments, bit0 = a … bit6 = g.
- digit  output  4  last accepted valid digit.
- digit_valid  output  1  digit holds a decoded value.
- invalid_pattern  output  1  level; the accepted pattern is not a hex glyph.
- step_pulse  output  1  1-cycle pulse when the accepted digit equals previous + 1 mod 16.
- wrap_pulse  output  1  1-cycle pulse on an F→0 step, coincident with step_pulse.
- error_skip  output  1  1-cycle pulse when a valid digit is accepted that is not previous + 1.
- period  output  CNT_W  clock cycles between the last two step_pulses.
- period_valid  output  1  period holds a measurement.

Behaviour:
- Reset (async, reset_n = 0): all outputs 0, all registers cleared, FSM = EMPTY. Counting resumes on the first edge after release.
- Input stage: seg_in is registered once (seg_q). stab_cnt counts consecutive edges where seg_q is unchanged and saturates at STABLE_CYCLES. Any change reloads stab_cnt to 1.
- Acceptance: a pattern is accepted on the edge at which stab_cnt reaches STABLE_CYCLES and seg_q differs from the currently accepted pattern. Latency from a seg_in change to the output update is STABLE_CYCLES + 1 edges. Patterns that change faster than this are never accepted.
- Decode table (hex, active-low), digits 0–F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E. Any other pattern is invalid.
- Interval counter: increments every enabled cycle and saturates at all-ones. It clears to 1 on each accept event in states EMPTY and HAVE_DIGIT, and on every step.
- FSM states: EMPTY, HAVE_DIGIT, HAVE_STEP, LOCKED.
  - EMPTY + valid accept → HAVE_DIGIT; digit loaded, digit_valid = 1, no pulses.
  - HAVE_DIGIT + step → HAVE_STEP; step_pulse asserted.
  - HAVE_STEP + step → LOCKED; period = interval, period_valid = 1.
  - LOCKED + step → LOCKED; period updated.
  - Any state except EMPTY + valid non-step accept → HAVE_DIGIT; error_skip asserted, period_valid = 0, digit updated.
  - Any state + invalid accept → EMPTY; invalid_pattern = 1, digit_valid = 0, period_valid = 0, digit holds its old value.
  - invalid_pattern stays high until a valid pattern is accepted.
- Period value: the difference between the edge numbers of the two step_pulses, e.g. pulses at edges 100 and 150 → period = 50. If the counter saturated, period = all-ones.
- A step from F to 0 sets step_pulse and wrap_pulse together.
- Repeating the same digit (no pattern change) is not an accept event and produces no pulses.
- enable = 0: seg_q, stab_cnt, interval counter and FSM all hold, and pulses are forced to 0. Level outputs hold their values.
- Reset mid-measurement discards all state, and no pulse is emitted on reset release.

Optional Feature:
- Macro: HEX_RATE_MONITOR_RATE_CLASS_EN.
- When defined, adds output rate_sel [1:0], registered and updated together with period. It classifies period against the counter's speed selects:
  - period < 2 → 00
  - period < 52,500,000 → 01
  - period < 150,000,000 → 10
  - otherwise → 11
- rate_sel is 00 whenever period_valid = 0.
- When not defined, the port and the classifier logic are absent and the rest of the behaviour is identical.

Test Plan:
- STABLE_CYCLES = 4; reset, then seg_in = 40 held → digit = 0 and digit_valid = 1 at edge 5 after the change; no pulses.
- Drive 40, 79, 24, changing every 20 cycles → step_pulse at both changes; after the second step, period = 20 and period_valid = 1.
- Drive 0E then 40 → step_pulse and wrap_pulse asserted in the same cycle.
- From LOCKED digit 2, drive 19 (digit 4) → error_skip pulse, period_valid = 0, digit = 4.
- Drive 7F (all segments off) → invalid_pattern = 1, digit_valid = 0; then 40 → back to HAVE_DIGIT with no error_skip.
- A 2-cycle glitch to 00 between stable 40 values → no accept and no pulses. Separately, pulsing reset_n low mid-interval → all outputs 0 immediately.

Source files
------------

// File: rtl/hex_rate_monitor_if.sv
// Segment-bus monitor interface: stimulus side (enable, seg_in) and the
// decoded digit / step / period results.
// Optional rate_sel signal exists only with HEX_RATE_MONITOR_RATE_CLASS_EN.
interface hex_rate_monitor_if #(parameter int CNT_W = 28);
  logic             enable;
  logic [6:0]       seg_in;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             invalid_pattern;
  logic             step_pulse;
  logic             wrap_pulse;
  logic             error_skip;
  logic [CNT_W-1:0] period;
  logic             period_valid;
`ifdef HEX_RATE_MONITOR_RATE_CLASS_EN
  logic [1:0]       rate_sel;

  modport master (output enable, seg_in,
                  input  digit, digit_valid, invalid_pattern, step_pulse, wrap_pulse,
                         error_skip, period, period_valid, rate_sel);
  modport slave  (input  enable, seg_in,
                  output digit, digit_valid, invalid_pattern, step_pulse, wrap_pulse,
                         error_skip, period, period_valid, rate_sel);
`else
  modport master (output enable, seg_in,
                  input  digit, digit_valid, invalid_pattern, step_pulse, wrap_pulse,
                         error_skip, period, period_valid);
  modport slave  (input  enable, seg_in,
                  output digit, digit_valid, invalid_pattern, step_pulse, wrap_pulse,
                         error_skip, period, period_valid);
`endif
endinterface

// File: rtl/hex_rate_monitor.sv
// hex_rate_monitor: debounces an active-low 7-segment bus, decodes it back to
// a hex digit, checks +1 mod 16 advances and measures the cycles between steps.
// Optional feature macro: HEX_RATE_MONITOR_RATE_CLASS_EN (adds rate_sel).
module hex_rate_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 28
) (
  input logic               clock,
  input logic               reset_n,
  hex_rate_monitor_if.slave bus
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {EMPTY, HAVE_DIGIT, HAVE_STEP, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [6:0]       seg_q, acc_pat;
  logic             acc_have;
  logic [SW-1:0]    stab_cnt;
  logic [CNT_W-1:0] interval, period_r;
  logic [3:0]       digit_r, dec_val;
  logic             dec_ok, accept, is_step;
  logic             dvalid_r, inv_r, step_r, wrap_r, skip_r, pvalid_r;
  logic             load_digit, do_step, do_wrap, do_skip, do_period, do_inval, clr_int;

  // A new pattern is taken once it has been seen STABLE_CYCLES times in a row;
  // acc_have lets the very first pattern after reset be taken even if it is 00.
  assign accept  = bus.enable && (stab_cnt == SW'(STABLE_CYCLES)) &&
                   (!acc_have || (seg_q != acc_pat));
  assign is_step = (state != EMPTY) && dec_ok && (dec_val == digit_r + 4'd1);

  // Decode the registered active-low pattern to a hex digit
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (seg_q)
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // Input register plus run-length of identical samples; remembers the accepted pattern
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_q    <= '0;
      stab_cnt <= '0;
      acc_pat  <= '0;
      acc_have <= 1'b0;
    end else if (bus.enable) begin
      seg_q <= bus.seg_in;
      if (bus.seg_in != seg_q)                 stab_cnt <= SW'(1);
      else if (stab_cnt != SW'(STABLE_CYCLES)) stab_cnt <= stab_cnt + 1'b1;
      if (accept) begin
        acc_pat  <= seg_q;
        acc_have <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  // FSM next state: only accept events move it
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (!dec_ok)             state_nxt = EMPTY;
      else if (state == EMPTY) state_nxt = HAVE_DIGIT;
      else if (is_step)        state_nxt = (state == HAVE_DIGIT) ? HAVE_STEP : LOCKED;
      else                     state_nxt = HAVE_DIGIT;
    end
  end

  // FSM outputs: per-accept actions for the datapath
  always_comb begin
    load_digit = 1'b0;
    do_step    = 1'b0;
    do_wrap    = 1'b0;
    do_skip    = 1'b0;
    do_period  = 1'b0;
    do_inval   = 1'b0;
    clr_int    = 1'b0;
    if (accept) begin
      if (!dec_ok) begin
        do_inval = 1'b1;
        clr_int  = (state == EMPTY) || (state == HAVE_DIGIT);
      end else if (state == EMPTY) begin
        load_digit = 1'b1;
        clr_int    = 1'b1;
      end else if (is_step) begin
        load_digit = 1'b1;
        do_step    = 1'b1;
        do_wrap    = (digit_r == 4'hF);
        do_period  = (state == HAVE_STEP) || (state == LOCKED);
        clr_int    = 1'b1;
      end else begin
        load_digit = 1'b1;
        do_skip    = 1'b1;
        clr_int    = (state == HAVE_DIGIT);
      end
    end
  end

  // Saturating interval counter; restarts at 1 so a step-to-step gap of N edges reads N
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                interval <= '0;
    else if (bus.enable) begin
      if (clr_int)               interval <= CNT_W'(1);
      else if (interval != '1)   interval <= interval + CNT_W'(1);
    end
  end

  // Registered outputs; pulses only ever last one cycle because accept implies enable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      digit_r  <= '0;
      dvalid_r <= 1'b0;
      inv_r    <= 1'b0;
      step_r   <= 1'b0;
      wrap_r   <= 1'b0;
      skip_r   <= 1'b0;
      period_r <= '0;
      pvalid_r <= 1'b0;
    end else begin
      step_r <= do_step;
      wrap_r <= do_wrap;
      skip_r <= do_skip;
      if (load_digit) begin
        digit_r  <= dec_val;
        dvalid_r <= 1'b1;
        inv_r    <= 1'b0;
      end
      if (do_inval) begin
        inv_r    <= 1'b1;
        dvalid_r <= 1'b0;
        pvalid_r <= 1'b0;
      end
      if (do_skip) pvalid_r <= 1'b0;
      if (do_period) begin
        period_r <= interval;
        pvalid_r <= 1'b1;
      end
    end
  end

  assign bus.digit           = digit_r;
  assign bus.digit_valid     = dvalid_r;
  assign bus.invalid_pattern = inv_r;
  assign bus.step_pulse      = step_r & bus.enable;
  assign bus.wrap_pulse      = wrap_r & bus.enable;
  assign bus.error_skip      = skip_r & bus.enable;
  assign bus.period          = period_r;
  assign bus.period_valid    = pvalid_r;

`ifdef HEX_RATE_MONITOR_RATE_CLASS_EN
  logic [1:0] rate_r;

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] p);
    if (64'(p) < 64'd2)                classify = 2'b00;
    else if (64'(p) < 64'd52_500_000)  classify = 2'b01;
    else if (64'(p) < 64'd150_000_000) classify = 2'b10;
    else                               classify = 2'b11;
  endfunction

  // Speed class follows period and drops to 00 whenever period_valid drops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 rate_r <= 2'b00;
    else if (do_period)           rate_r <= classify(interval);
    else if (do_inval || do_skip) rate_r <= 2'b00;
  end

  assign bus.rate_sel = rate_r;
`endif
endmodule

// File: tb/tb_hex_rate_monitor.sv
// Bench for hex_rate_monitor: directed test-plan steps followed by random
// segment traffic, every cycle compared against an event-level reference model.
module tb_hex_rate_monitor;
  localparam int STABLE = 4;
  localparam int CW     = 28;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  hex_rate_monitor_if #(.CNT_W(CW)) bus();

  hex_rate_monitor #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  logic [6:0] tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state
  logic [6:0] hist[$];
  logic [6:0] acc_pat;
  logic       acc_have, have;
  int         chain, last_step, en_edge, m_period;
  logic [3:0] m_digit;
  logic       m_dv, m_inv, m_pv, m_step, m_wrap, m_skip;
  int         n_step, n_sw, n_skip;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    hist.delete();
    acc_pat = '0; acc_have = 0; have = 0; chain = 0; last_step = 0; en_edge = 0;
    m_period = 0; m_digit = '0; m_dv = 0; m_inv = 0; m_pv = 0;
    m_step = 0; m_wrap = 0; m_skip = 0;
  endtask

  task automatic apply_accept(input logic [6:0] p);
    int d;
    d = -1;
    for (int i = 0; i < 16; i++) if (tab[i] == p) d = i;
    acc_have = 1; acc_pat = p;
    if (d < 0) begin
      m_inv = 1; m_dv = 0; m_pv = 0; have = 0; chain = 0;
    end else if (!have) begin
      have = 1; m_digit = 4'(d); m_dv = 1; m_inv = 0; chain = 0;
    end else if ((int'(m_digit) + 1) % 16 == d) begin
      m_step = 1;
      m_wrap = (m_digit == 4'hF);
      if (chain >= 1) begin
        m_period = en_edge - last_step;
        m_pv = 1;
      end
      chain++;
      last_step = en_edge;
      m_digit = 4'(d);
    end else begin
      m_skip = 1; m_pv = 0; chain = 0; m_digit = 4'(d);
    end
  endtask

  // one clock edge of the model: a pattern seen in the last STABLE samples
  // and different from the accepted one becomes the new accepted pattern
  task automatic model_edge();
    logic same;
    m_step = 0; m_wrap = 0; m_skip = 0;
    if (!bus.enable) return;
    en_edge++;
    same = (hist.size() == STABLE);
    foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
    if (same && (!acc_have || hist[0] != acc_pat)) apply_accept(hist[0]);
    hist.push_back(bus.seg_in);
    if (hist.size() > STABLE) void'(hist.pop_front());
  endtask

  task automatic compare_all(input string t);
    check({t, ".digit"},  64'(bus.digit),           64'(m_digit));
    check({t, ".dvalid"}, 64'(bus.digit_valid),     64'(m_dv));
    check({t, ".inv"},    64'(bus.invalid_pattern), 64'(m_inv));
    check({t, ".step"},   64'(bus.step_pulse),      64'(m_step & bus.enable));
    check({t, ".wrap"},   64'(bus.wrap_pulse),      64'(m_wrap & bus.enable));
    check({t, ".skip"},   64'(bus.error_skip),      64'(m_skip & bus.enable));
    check({t, ".pvalid"}, 64'(bus.period_valid),    64'(m_pv));
    check({t, ".period"}, 64'(bus.period),          64'(m_period));
`ifdef HEX_RATE_MONITOR_RATE_CLASS_EN
    check({t, ".rate"}, 64'(bus.rate_sel),
          !m_pv ? 64'd0 : m_period < 2 ? 64'd0 : m_period < 52_500_000 ? 64'd1 :
          m_period < 150_000_000 ? 64'd2 : 64'd3);
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    compare_all("cyc");
    if (bus.step_pulse) n_step++;
    if (bus.step_pulse && bus.wrap_pulse) n_sw++;
    if (bus.error_skip) n_skip++;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    bus.seg_in = p;
    repeat (n) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, n;
    logic [6:0] p;
    n_step = 0; n_sw = 0; n_skip = 0;
    bus.enable = 1'b1;
    bus.seg_in = 7'h40;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    compare_all("reset");
    reset_n = 1'b1;

    // first accept lands on the 5th edge after release
    repeat (4) tick();
    check("accept_early.dvalid", 64'(bus.digit_valid), 64'd0);
    tick();
    check("accept.dvalid", 64'(bus.digit_valid), 64'd1);
    check("accept.digit",  64'(bus.digit),       64'd0);
    check("accept.nopulse", 64'(n_step + n_skip), 64'd0);
    hold(7'h40, 15);

    // two steps 20 cycles apart -> period 20
    hold(7'h79, 20);
    hold(7'h24, 20);
    check("two_steps.count", 64'(n_step), 64'd2);
    check("two_steps.period", 64'(bus.period), 64'd20);
    check("two_steps.pvalid", 64'(bus.period_valid), 64'd1);

    // skip from locked digit 2 to 4
    hold(7'h19, 10);
    check("skip.count", 64'(n_skip), 64'd1);
    check("skip.pvalid", 64'(bus.period_valid), 64'd0);
    check("skip.digit", 64'(bus.digit), 64'd4);

    // blank display is invalid, then recovery without error_skip
    hold(7'h7F, 10);
    check("blank.inv", 64'(bus.invalid_pattern), 64'd1);
    check("blank.dvalid", 64'(bus.digit_valid), 64'd0);
    hold(7'h40, 10);
    check("recover.skip", 64'(n_skip), 64'd1);
    check("recover.dvalid", 64'(bus.digit_valid), 64'd1);
    check("recover.inv", 64'(bus.invalid_pattern), 64'd0);

    // F -> 0 wraps
    hold(7'h0E, 10);
    hold(7'h40, 10);
    check("wrap.coincident", 64'(n_sw), 64'd1);

    // short glitch is ignored
    n = n_step + n_skip;
    hold(7'h00, 2);
    hold(7'h40, 10);
    check("glitch.nopulse", 64'(n_step + n_skip), 64'(n));
    check("glitch.digit", 64'(bus.digit), 64'd0);

    // freeze: pattern change while disabled is not seen until enable returns
    bus.enable = 1'b0;
    hold(7'h79, 8);
    check("freeze.digit", 64'(bus.digit), 64'd0);
    bus.enable = 1'b1;
    hold(7'h79, 8);
    check("unfreeze.digit", 64'(bus.digit), 64'd1);

    // async reset in the middle of an interval
    hold(7'h24, 8);
    hold(7'h30, 3);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("midreset");
    @(posedge clock);
    #1 reset_n = 1'b1;
    n = n_step + n_skip;
    hold(7'h30, 10);
    check("postreset.nopulse", 64'(n_step + n_skip), 64'(n));
    check("postreset.digit", 64'(bus.digit), 64'd3);

    // random traffic
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      hold(tab[(int'(m_digit) + 1) % 16], $urandom_range(1, 30));
      else if (r < 75) hold(tab[$urandom_range(0, 15)], $urandom_range(1, 30));
      else if (r < 82) begin
        p = 7'($urandom);
        hold(p, $urandom_range(1, 20));
      end else if (r < 90) hold(tab[$urandom_range(0, 15)], $urandom_range(1, STABLE - 1));
      else begin
        bus.enable = 1'b0;
        hold(tab[$urandom_range(0, 15)], $urandom_range(1, 6));
        bus.enable = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
